// File: rtl/whac_pkg.sv
// rtl/whac_pkg.sv - shared types and constants for the whac-a-mole pipeline
package whac_pkg;

  typedef enum logic [1:0] {IDLE, DOWN, GEN, UP} state_t;

  localparam int                LFSR_W    = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam int                ROUND_W   = 8;

  // Right-shifting Galois step for x^32 + x^22 + x^2 + x + 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/mole_spawner_lfsr32.sv
// rtl/mole_spawner_lfsr32.sv - free-running 32-bit Galois LFSR
module lfsr32
  import whac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= seed;
    else        q <= lfsr_next(q);
  end

endmodule

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - round FSM that picks mole holes and sizes the up-window
module mole_spawner
  import whac_pkg::*;
#(
  parameter int                NUM_HOLES   = 18,
  parameter int                MAX_MOLES   = 3,
  parameter logic [31:0]       UP_INIT     = 32'd50_000_000,
  parameter logic [31:0]       UP_STEP     = 32'd2_000_000,
  parameter logic [31:0]       UP_MIN      = 32'd15_000_000,
  parameter logic [31:0]       DOWN_CYCLES = 32'd25_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 32'hACE1_2024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_in_progress,
  input  logic                 full_clear_hit,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic [ROUND_W-1:0]   round_count
);

  localparam logic [7:0]  HOLES8       = 8'(NUM_HOLES);
  localparam logic [7:0]  MOLES8       = 8'(MAX_MOLES);
  localparam logic [32:0] SHRINK_FLOOR = {1'b0, UP_MIN} + {1'b0, UP_STEP};

  logic [LFSR_W-1:0]    lfsr;
  logic [7:0]           idx;
  logic [7:0]           k_draw;
  logic [NUM_HOLES-1:0] hole_bit;
  logic                 lfsr_hi_unused;

  state_t               state;
  logic [31:0]          up_time;
  logic [31:0]          timer;
  logic [7:0]           gen_left;
  logic [NUM_HOLES-1:0] pattern;

  lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign idx            = lfsr[7:0] % HOLES8;
  assign k_draw         = 8'd1 + (lfsr[15:8] % MOLES8);
  assign hole_bit       = {{(NUM_HOLES-1){1'b0}}, 1'b1} << idx;
  assign lfsr_hi_unused = ^lfsr[LFSR_W-1:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mole_positions <= '0;
      round_count    <= '0;
      up_time        <= UP_INIT;
      timer          <= '0;
      gen_left       <= '0;
      pattern        <= '0;
    end else if (!game_in_progress) begin
      // Abandoning a game discards the round in flight; the LFSR keeps running.
      state          <= IDLE;
      mole_positions <= '0;
      round_count    <= '0;
      up_time        <= UP_INIT;
    end else begin
      case (state)
        IDLE: begin
          state <= DOWN;
          timer <= DOWN_CYCLES - 32'd1;
        end
        DOWN: begin
          if (timer == '0) begin
            state    <= GEN;
            gen_left <= k_draw;
            pattern  <= '0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        GEN: begin
          // Last draw is folded straight into the output so UP starts populated.
          pattern  <= pattern | hole_bit;
          gen_left <= gen_left - 8'd1;
          if (gen_left == 8'd1) begin
            state          <= UP;
            mole_positions <= pattern | hole_bit;
            timer          <= up_time - 32'd1;
          end
        end
        UP: begin
          if (full_clear_hit || timer == '0) begin
            state          <= DOWN;
            mole_positions <= '0;
            timer          <= DOWN_CYCLES - 32'd1;
            if (round_count != '1) round_count <= round_count + 1'b1;
            up_time <= ({1'b0, up_time} >= SHRINK_FLOOR) ? up_time - UP_STEP : UP_MIN;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// tb/tb_mole_spawner.sv - self-checking bench for mole_spawner
module tb_mole_spawner;

  localparam int          NH   = 18;
  localparam int          MM   = 3;
  localparam int          UPI  = 20;
  localparam int          UPS  = 5;
  localparam int          UPM  = 8;
  localparam int          DC   = 4;
  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          game_in_progress = 1'b0;
  logic          full_clear_hit = 1'b0;
  logic [NH-1:0] mole_positions;
  logic [7:0]    round_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int next_s;
  int mdl_up;
  int mdl_rc;

  typedef struct {
    int hit_off;
    int win;
    int rc;
    bit gap;
  } vec_t;

  vec_t tbl[7];

  mole_spawner #(
    .NUM_HOLES   (NH),
    .MAX_MOLES   (MM),
    .UP_INIT     (32'd20),
    .UP_STEP     (32'd5),
    .UP_MIN      (32'd8),
    .DOWN_CYCLES (32'd4),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .game_in_progress (game_in_progress),
    .full_clear_hit   (full_clear_hit),
    .mole_positions   (mole_positions),
    .round_count      (round_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Value of the polynomial register after n steps from the seed.
  function automatic logic [31:0] lfsr_after(input int n);
    logic [31:0] v;
    logic        lsb;
    v = SEED;
    for (int i = 0; i < n; i++) begin
      lsb = v[0];
      v   = v >> 1;
      if (lsb) v = v ^ 32'h8020_0003;
    end
    return v;
  endfunction

  function automatic int mdl_k(input int s);
    logic [31:0] v;
    v = lfsr_after(s);
    return 1 + (int'(v[15:8]) % MM);
  endfunction

  function automatic logic [NH-1:0] mdl_pat(input int s, input int k);
    logic [31:0]   v;
    logic [NH-1:0] p;
    p = '0;
    for (int j = 1; j <= k; j++) begin
      v = lfsr_after(s + j);
      p[int'(v[7:0]) % NH] = 1'b1;
    end
    return p;
  endfunction

  function automatic int sat_inc(input int r);
    return (r >= 255) ? 255 : r + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic restart_model();
    next_s = cyc + DC;
    mdl_up = UPI;
    mdl_rc = 0;
  endtask

  // Entered at a negedge with mole_positions zero; returns at the first zero after the window.
  task automatic run_round(input int hit_off, input int exp_win, input int exp_rc, input bit chk_gap);
    int            s;
    int            k;
    int            n;
    int            win;
    logic [NH-1:0] pat;
    s   = next_s;
    k   = mdl_k(s);
    pat = mdl_pat(s, k);
    n   = 0;
    while (mole_positions == '0 && n < 300) begin
      full_clear_hit = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      n++;
    end
    full_clear_hit = 1'b0;
    check("start_cycle", cyc, s + k + 1);
    check("pattern", mole_positions, pat);
    check("popcount_in_range",
          ($countones(mole_positions) >= 1 && $countones(mole_positions) <= MM), 1);
    if (chk_gap) check("zero_gap", n, DC + k);
    win = 0;
    while (mole_positions != '0 && win < 300) begin
      if (win == hit_off) full_clear_hit = 1'b1;
      @(negedge clk);
      full_clear_hit = 1'b0;
      win++;
    end
    check("up_window", win, exp_win);
    check("round_count", round_count, exp_rc);
    next_s = cyc - 1 + DC;
    mdl_up = (mdl_up - UPS < UPM) ? UPM : mdl_up - UPS;
    mdl_rc = sat_inc(mdl_rc);
  endtask

  task automatic wait_moles();
    int n;
    n = 0;
    while (mole_positions == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("moles_appear", (mole_positions != '0), 1);
  endtask

  initial begin
    int hit;
    int w;
    int n;

    tbl[0] = '{-1, 20, 1, 1'b0};
    tbl[1] = '{-1, 15, 2, 1'b1};
    tbl[2] = '{-1, 10, 3, 1'b1};
    tbl[3] = '{-1,  8, 4, 1'b1};
    tbl[4] = '{-1,  8, 5, 1'b1};
    tbl[5] = '{ 2,  3, 6, 1'b1};
    tbl[6] = '{ 7,  8, 7, 1'b1};

    repeat (3) @(negedge clk);
    check("reset_moles", mole_positions, 0);
    check("reset_round_count", round_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      full_clear_hit = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_moles", mole_positions, 0);
      check("idle_round_count", round_count, 0);
    end
    full_clear_hit = 1'b0;

    game_in_progress = 1'b1;
    restart_model();
    for (int i = 0; i < 7; i++) run_round(tbl[i].hit_off, tbl[i].win, tbl[i].rc, tbl[i].gap);

    wait_moles();
    repeat (2) @(negedge clk);
    game_in_progress = 1'b0;
    @(negedge clk);
    check("drop_moles", mole_positions, 0);
    check("drop_round_count", round_count, 0);
    repeat (3) @(negedge clk);
    game_in_progress = 1'b1;
    restart_model();
    run_round(2, 3, 1, 1'b0);
    run_round(-1, 15, 2, 1'b1);

    n = 0;
    while (cyc < next_s + 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("reset_gen_moles", mole_positions, 0);
    check("reset_gen_round_count", round_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    restart_model();
    run_round(-1, 20, 1, 1'b0);

    wait_moles();
    #2 rst_n = 1'b0;
    #1;
    check("reset_up_moles", mole_positions, 0);
    check("reset_up_round_count", round_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    restart_model();

    for (int i = 0; i < 20; i++) begin
      hit = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, mdl_up + 2));
      w   = (hit >= 0 && hit < mdl_up) ? hit + 1 : mdl_up;
      run_round(hit, w, sat_inc(mdl_rc), (i != 0));
    end

    for (int i = 0; i < 260; i++) run_round(0, 1, sat_inc(mdl_rc), 1'b1);
    check("saturated_round_count", round_count, 255);

    game_in_progress = 1'b0;
    @(negedge clk);
    check("final_idle_moles", mole_positions, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
# mole_spawner

Upstream stage of the hit detector: decides when moles appear, where, and for how long, and drives the one-hot-per-hole `mole_positions` vector that the hit stage edge-detects. Runs a free-running 32-bit LFSR, a DOWN/GEN/UP round state machine and a shrinking up-window (difficulty ramp). A full-clear hit ends the up-window early.

## Interface
- `NUM_HOLES`, 18: hole count; legal range 2..32.
- `MAX_MOLES`, 3: maximum moles per round; legal range 1..NUM_HOLES.
- `UP_INIT`, 50_000_000: up-window length in cycles for round 0.
- `UP_STEP`, 2_000_000: cycles removed from the up-window after each round.
- `UP_MIN`, 15_000_000: floor on the up-window.
- `DOWN_CYCLES`, 25_000_000: cycles with no moles between rounds; ≥1.
- `LFSR_SEED`, 32'hACE1_2024: LFSR reset value; nonzero.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `game_in_progress`  in  1  level; low forces IDLE.
- `full_clear_hit`  in  1  one-cycle pulse from the hit stage; last mole of the round was hit.
- `mole_positions`  out  NUM_HOLES  registered; bit i high = mole up in hole i.
- `round_count`  out  8  completed rounds this game; saturates at 255.

## Operation
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1. Advances every cycle in all states after reset, never zero.
- `idx = lfsr[7:0] mod NUM_HOLES`. `k = 1 + (lfsr[15:8] mod MAX_MOLES)`.
- States:
  - IDLE: outputs zero, `up_time = UP_INIT`, `round_count = 0`. Goes to DOWN when `game_in_progress = 1`.
  - DOWN: wait DOWN_CYCLES cycles, then go to GEN. On GEN entry, latch `k` and clear the pattern register.
  - GEN: for k cycles, set `pattern[idx]`. Duplicate indices are allowed and reduce the mole count. Then go to UP and load `mole_positions = pattern`.
  - UP: hold `mole_positions` for `up_time` cycles, or until `full_clear_hit`, whichever comes first. Then go to DOWN, clear `mole_positions`, increment `round_count` (saturating), and set `up_time = max(up_time − UP_STEP, UP_MIN)`.
- The pattern is nonzero on UP entry by construction, since k ≥ 1.
- `game_in_progress = 0` in any state: next cycle is IDLE with outputs zero. Any round in progress is discarded and not counted. The LFSR is not reset.
- `full_clear_hit` outside UP is ignored.
- `up_time` arithmetic is 32-bit. The subtraction is clamped: never underflows, never goes below UP_MIN.

## Timing
- Reset values: `mole_positions = 0`, `round_count = 0`, state IDLE, `up_time = UP_INIT`, `lfsr = LFSR_SEED`.
- `game_in_progress` rises at cycle t: DOWN from t+1. First nonzero `mole_positions` appears at t+1+DOWN_CYCLES+k.
- Per round, `mole_positions` is nonzero for exactly `up_time` consecutive cycles, unless cut short.
- `full_clear_hit` high at cycle t in UP: `mole_positions = 0` and `round_count` updated at t+1.
- Timer expiry and `full_clear_hit` in the same cycle: a single transition; the round is counted once.
- Between rounds, `mole_positions` is zero for DOWN_CYCLES + k cycles (≥2). This guarantees the hit stage sees a falling and a rising edge every round.
- `rst_n` low mid-round: all state returns to reset values immediately (asynchronously).

## Structure
- `whac_pkg`: state enum (IDLE, DOWN, GEN, UP), `LFSR_W = 32`, `LFSR_TAPS = 32'h8020_0003`, `ROUND_W = 8`. Shared with the hit stage and the scoring block.
- One sub-module, `lfsr32`, with ports `clk`, `rst_n`, `seed`, `q`; free-running.
- The FSM, both timers and the pattern register live in `mole_spawner`.

## Test plan
Test parameters: UP_INIT=20, UP_STEP=5, UP_MIN=8, DOWN_CYCLES=4, MAX_MOLES=3, NUM_HOLES=18.
1. Reset, then hold `game_in_progress = 0` for 100 cycles: `mole_positions = 0`, `round_count = 0`, state stays IDLE.
2. Raise `game_in_progress` with no hits: pattern and k match a C model of the LFSR from the seed; popcount is in 1..3; pattern is held exactly 20 cycles; `round_count = 1` at the falling edge.
3. Run rounds 2..5 with no hits: up-windows are 15, 10, 8, 8 cycles; zero gaps are 4+k cycles.
4. Pulse `full_clear_hit` on the 3rd cycle of an UP: `mole_positions = 0` next cycle; `round_count` increments once; next window follows the shrink rule. Repeat with the pulse on the timer-expiry cycle: single increment.
5. Drop `game_in_progress` mid-UP, then re-raise: outputs zero next cycle; `round_count = 0`; first window after re-raise is 20 cycles. Assert `rst_n` mid-GEN: outputs zero immediately.
6. Force 256 short rounds: `round_count` saturates at 255.
